jtgng_vidtimer: RTL and testbench



---
 rtl/jtgng_vidtimer.sv | 107 ++++++++++
 tb/tb_jtgng_vidtimer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/jtgng_vidtimer.sv
// jtgng_vidtimer -- native 15 kHz raster timing generator.
//
// Produces the pixel/line counters and the blanking, sync and init strobes
// that feed the VGA scan doubler, the 15 kHz analogue output and the
// tile/sprite engines. Everything advances on clk edges qualified by cen6.
//
// Ports:
//   clk    in   system clock (24 MHz)
//   rst    in   asynchronous active-high reset
//   cen6   in   pixel clock enable (normally 1-in-4 clk cycles)
//   H      out  horizontal pixel count, 0..HCNT_END
//   V      out  line count, 0..VCNT_END
//   LHBL   out  active-low horizontal blank
//   LVBL   out  active-low vertical blank
//   HS     out  horizontal sync, active high
//   VS     out  vertical sync, active high
//   Hinit  out  high while H==0
//   Vinit  out  high while H==0 and V==0
//   frame  out  toggles once per frame
module jtgng_vidtimer #(
    parameter int HCNT_END = 383,
    parameter int HB_START = 256,
    parameter int HB_END   = 0,
    parameter int HS_START = 290,
    parameter int HS_END   = 318,
    parameter int VCNT_END = 263,
    parameter int VB_START = 240,
    parameter int VB_END   = 16,
    parameter int VS_START = 248,
    parameter int VS_END   = 252
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen6,
    output logic [8:0] H,
    output logic [8:0] V,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       Hinit,
    output logic       Vinit,
    output logic       frame
);

    localparam logic [8:0] HEND = 9'(HCNT_END);
    localparam logic [8:0] VEND = 9'(VCNT_END);
    localparam logic [8:0] HBS  = 9'(HB_START);
    localparam logic [8:0] HBE  = 9'(HB_END);
    localparam logic [8:0] HSS  = 9'(HS_START);
    localparam logic [8:0] HSE  = 9'(HS_END);
    localparam logic [8:0] VBS  = 9'(VB_START);
    localparam logic [8:0] VBE  = 9'(VB_END);
    localparam logic [8:0] VSS  = 9'(VS_START);
    localparam logic [8:0] VSE  = 9'(VS_END);

    // Half-open window test [lo, hi).
    function automatic logic in_win(input logic [8:0] x,
                                    input logic [8:0] lo,
                                    input logic [8:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;

    always_comb begin
        h_wrap = (H == HEND);
        v_wrap = (V == VEND);
        h_nxt  = h_wrap ? '0 : H + 9'd1;
        v_nxt  = V;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : V + 9'd1;
        end
    end

    // Strobes decode the next counter values so they register on the same
    // edge as the H/V they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            H     <= '0;
            V     <= '0;
            LHBL  <= 1'b0;
            LVBL  <= 1'b0;
            HS    <= 1'b0;
            VS    <= 1'b0;
            Hinit <= 1'b0;
            Vinit <= 1'b0;
            frame <= 1'b0;
        end else if (cen6) begin
            H     <= h_nxt;
            V     <= v_nxt;
            LHBL  <= in_win(h_nxt, HBE, HBS);
            LVBL  <= in_win(v_nxt, VBE, VBS);
            HS    <= in_win(h_nxt, HSS, HSE);
            VS    <= in_win(v_nxt, VSS, VSE);
            Hinit <= (h_nxt == '0);
            Vinit <= (h_nxt == '0) && (v_nxt == '0);
            if (h_wrap && v_wrap) begin
                frame <= ~frame;
            end
        end
    end

endmodule

// File: tb/tb_jtgng_vidtimer.sv
// tb_jtgng_vidtimer -- self-checking bench for jtgng_vidtimer.
//
// A reduced raster keeps whole frames short. The reference model only counts
// pixel enables since reset and derives every output arithmetically from
// that count.
module tb_jtgng_vidtimer;

    localparam int HCNT_END = 47;
    localparam int HB_START = 34;
    localparam int HB_END   = 2;
    localparam int HS_START = 38;
    localparam int HS_END   = 44;
    localparam int VCNT_END = 21;
    localparam int VB_START = 18;
    localparam int VB_END   = 3;
    localparam int VS_START = 19;
    localparam int VS_END   = 21;

    localparam int LW = HCNT_END + 1;   // pixels per line
    localparam int FH = VCNT_END + 1;   // lines per frame

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       cen6 = 1'b0;
    logic [8:0] H;
    logic [8:0] V;
    logic       LHBL;
    logic       LVBL;
    logic       HS;
    logic       VS;
    logic       Hinit;
    logic       Vinit;
    logic       frame;

    always #5 clk = ~clk;

    jtgng_vidtimer #(
        .HCNT_END (HCNT_END),
        .HB_START (HB_START),
        .HB_END   (HB_END),
        .HS_START (HS_START),
        .HS_END   (HS_END),
        .VCNT_END (VCNT_END),
        .VB_START (VB_START),
        .VB_END   (VB_END),
        .VS_START (VS_START),
        .VS_END   (VS_END)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cen6  (cen6),
        .H     (H),
        .V     (V),
        .LHBL  (LHBL),
        .LVBL  (LVBL),
        .HS    (HS),
        .VS    (VS),
        .Hinit (Hinit),
        .Vinit (Vinit),
        .frame (frame)
    );

    int          tests   = 0;
    int          fails   = 0;
    int unsigned n       = 0;     // pixel enables seen since reset release
    bit          started = 1'b0;  // at least one enable since reset

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t enables=%0d)",
                     tag, got, exp, $time, n);
        end
    endtask

    task automatic check_all();
        int unsigned h, v, f;
        bit e_hb, e_vb, e_hs, e_vs, e_hi, e_vi;
        h = n % LW;
        v = (n / LW) % FH;
        f = (n / (LW * FH)) % 2;
        e_hb = started && (h >= HB_END)   && (h < HB_START);
        e_vb = started && (v >= VB_END)   && (v < VB_START);
        e_hs = started && (h >= HS_START) && (h < HS_END);
        e_vs = started && (v >= VS_START) && (v < VS_END);
        e_hi = started && (h == 0);
        e_vi = started && (h == 0) && (v == 0);
        chk("H",     32'(H),     h);
        chk("V",     32'(V),     v);
        chk("frame", 32'(frame), f);
        chk("LHBL",  32'(LHBL),  32'(e_hb));
        chk("LVBL",  32'(LVBL),  32'(e_vb));
        chk("HS",    32'(HS),    32'(e_hs));
        chk("VS",    32'(VS),    32'(e_vs));
        chk("Hinit", 32'(Hinit), 32'(e_hi));
        chk("Vinit", 32'(Vinit), 32'(e_vi));
    endtask

    // One clk cycle: drive cen6 at the falling edge, check #1 after rising.
    task automatic step(input bit c);
        @(negedge clk);
        cen6 = c;
        @(posedge clk);
        if (c && !rst) begin
            n++;
            started = 1'b1;
        end
        #1;
        check_all();
    endtask

    // Assert reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n       = 0;
        started = 1'b0;
        check_all();
        repeat (3) step(1'($urandom % 2));
        @(negedge clk);
        rst  = 1'b0;
        cen6 = 1'b0;
    endtask

    initial begin
        repeat (3) step(1'b1);     // held in reset: enables ignored
        @(negedge clk);
        rst  = 1'b0;
        cen6 = 1'b0;

        // Nominal 1-in-4 enables over three frames.
        for (int i = 0; i < 3 * LW * FH * 4; i++) begin
            step(i % 4 == 3);
        end

        // Continuous enable over two frames.
        repeat (2 * LW * FH) step(1'b1);

        // Long gaps with cen6 low at arbitrary points.
        repeat (5) begin
            repeat ($urandom_range(50, 300)) step(1'b1);
            repeat (100) step(1'b0);
        end

        // Mid-raster reset, then sparse random enables with occasional resets.
        do_reset();
        repeat (4000) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 2) == 0);
        end

        do_reset();
        repeat (2 * LW * FH + 17) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
